fetch_stage: RTL and testbench

IF stage of the 5-stage MIPS pipeline: the PC register, next-PC selection and the IF/ID pipeline register. It sits directly upstream of the load-use hazard unit and consumes that unit's pc_write / IF_ID_write outputs. It also consumes the branch/jump redirect and flush from later stages. It drives the instruction memory address and presents the fetched instruction, PC+4 and a valid bit to ID.

---
 rtl/fetch_stage_if.sv | 8 +
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
interface fetch_stage_if;
  logic [31:0] addr;
  logic [31:0] data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, and the IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to build the saturating stall/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0040_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write_i,
  input  logic                 IF_ID_write_i,
  input  logic                 flush_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_target_i,
  input  logic                 jump_i,
  input  logic [31:0]          jump_target_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          IF_ID_instr_o,
  output logic [31:0]          IF_ID_pc_plus4_o,
  output logic                 IF_ID_valid_o,
  output logic                 misalign_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4Reg_q, pcPlus4Reg_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pcPlus4;
  logic        redirect;
  logic [31:0] redirectTarget;

  assign pcPlus4        = pc_q + 32'd4;
  assign redirect       = jump_i | branch_taken_i;
  assign redirectTarget = jump_i ? jump_target_i : branch_target_i;

  assign imem.addr        = pc_q;
  assign IF_ID_instr_o    = instr_q;
  assign IF_ID_pc_plus4_o = pcPlus4Reg_q;
  assign IF_ID_valid_o    = valid_q;
  assign misalign_o       = misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= PC_RESET;
      instr_q      <= '0;
      pcPlus4Reg_q <= '0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcPlus4Reg_q <= pcPlus4Reg_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // BOOT holds the PC for one edge so the first imem read settles before anything is latched.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcPlus4Reg_d = pcPlus4Reg_q;
    valid_d      = valid_q;
    misalign_d   = misalign_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!pc_write_i && !redirect) state_d = HOLD;
      HOLD:    if (pc_write_i || redirect)   state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (state_q == BOOT) begin
      instr_d      = '0;
      pcPlus4Reg_d = '0;
      valid_d      = 1'b0;
    end else begin
      if (redirect) begin
        pc_d = {redirectTarget[31:2], 2'b00};
        if (redirectTarget[1:0] != 2'b00) misalign_d = 1'b1;
      end else if (pc_write_i) begin
        pc_d = pcPlus4;
      end

      if (flush_i) begin
        instr_d      = '0;
        pcPlus4Reg_d = '0;
        valid_d      = 1'b0;
      end else if (IF_ID_write_i) begin
        instr_d      = imem.data;
        pcPlus4Reg_d = pcPlus4;
        valid_d      = 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (state_q != BOOT && !pc_write_i && stallCnt_q != '1)
        stallCnt_q <= stallCnt_q + CNT_WIDTH'(1);
      if (flush_i && flushCnt_q != '1)
        flushCnt_q <= flushCnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan items plus randomized traffic against a
// cycle-level reference model; a separate monitor pops expectations after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET  = 32'h0040_0000;
  localparam int          CNT_WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pcWrite = 1'b0, ifidWrite = 1'b0, flush = 1'b0;
  logic        branchTaken = 1'b0, jump = 1'b0;
  logic [31:0] branchTarget = '0, jumpTarget = '0;
  logic [31:0] ifidInstr, ifidPcPlus4;
  logic        ifidValid, misalign;
  logic [CNT_WIDTH-1:0] stallCnt, flushCnt;

  int testsRun = 0;
  int testsFailed = 0;

  fetch_stage_if bus();

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.data = memWord(bus.addr);

  fetch_stage #(.PC_RESET(PC_RESET), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_write_i       (pcWrite),
    .IF_ID_write_i    (ifidWrite),
    .flush_i          (flush),
    .branch_taken_i   (branchTaken),
    .branch_target_i  (branchTarget),
    .jump_i           (jump),
    .jump_target_i    (jumpTarget),
    .imem             (bus.master),
    .IF_ID_instr_o    (ifidInstr),
    .IF_ID_pc_plus4_o (ifidPcPlus4),
    .IF_ID_valid_o    (ifidValid),
    .misalign_o       (misalign),
    .stall_cnt_o      (stallCnt),
    .flush_cnt_o      (flushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
    logic        misalign;
    int          stallCnt;
    int          flushCnt;
  } expect_t;

  expect_t sbQueue[$];
  expect_t mon;
  int      stepNo = 0;

  // Reference model state: what the fetch stage should hold after the edge just modelled.
  logic [31:0] mPc, mInstr, mPcPlus4;
  logic        mValid, mMisalign, mBooting;
  int          mStall, mFlush;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = PC_RESET; mInstr = '0; mPcPlus4 = '0; mValid = 1'b0; mMisalign = 1'b0;
    mBooting = 1'b1; mStall = 0; mFlush = 0;
  endtask

  task automatic applyStimulus(input bit pcw, input bit ifidw, input bit fl, input bit br,
                               input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    logic [31:0] oldPc, tgt;
    expect_t     e;
    @(negedge clk);
    pcWrite = pcw; ifidWrite = ifidw; flush = fl;
    branchTaken = br; branchTarget = bt; jump = jp; jumpTarget = jt;
    oldPc = mPc;
    if (mBooting) begin
      mBooting = 1'b0;
      mInstr = '0; mPcPlus4 = '0; mValid = 1'b0;
    end else begin
      if (jp || br) begin
        tgt = jp ? jt : bt;
        if (tgt % 4 != 0) mMisalign = 1'b1;
        mPc = tgt - (tgt % 4);
      end else if (pcw) begin
        mPc = oldPc + 32'd4;
      end
      if (fl) begin
        mInstr = '0; mPcPlus4 = '0; mValid = 1'b0;
      end else if (ifidw) begin
        mInstr = memWord(oldPc); mPcPlus4 = oldPc + 32'd4; mValid = 1'b1;
      end
      if (!pcw && mStall < (1 << CNT_WIDTH) - 1) mStall++;
    end
    if (fl && mFlush < (1 << CNT_WIDTH) - 1) mFlush++;
    stepNo++;
    e.step = stepNo; e.pc = mPc; e.instr = mInstr; e.pcPlus4 = mPcPlus4;
    e.valid = mValid; e.misalign = mMisalign;
`ifdef FETCH_PERF_CNT_EN
    e.stallCnt = mStall; e.flushCnt = mFlush;
`else
    e.stallCnt = 0; e.flushCnt = 0;
`endif
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checkField($sformatf("pc@%0d", e.step), bus.addr, e.pc);
    checkField($sformatf("instr@%0d", e.step), ifidInstr, e.instr);
    checkField($sformatf("pcPlus4@%0d", e.step), ifidPcPlus4, e.pcPlus4);
    checkField($sformatf("valid@%0d", e.step), 32'(ifidValid), 32'(e.valid));
    checkField($sformatf("misalign@%0d", e.step), 32'(misalign), 32'(e.misalign));
    checkField($sformatf("stallCnt@%0d", e.step), 32'(stallCnt), 32'(e.stallCnt));
    checkField($sformatf("flushCnt@%0d", e.step), 32'(flushCnt), 32'(e.flushCnt));
  endtask

  task automatic checkResetValues(input string tag);
    checkField({tag, "_pc"}, bus.addr, PC_RESET);
    checkField({tag, "_instr"}, ifidInstr, 32'h0);
    checkField({tag, "_pcPlus4"}, ifidPcPlus4, 32'h0);
    checkField({tag, "_valid"}, 32'(ifidValid), 32'h0);
    checkField({tag, "_misalign"}, 32'(misalign), 32'h0);
    checkField({tag, "_stallCnt"}, 32'(stallCnt), 32'h0);
    checkField({tag, "_flushCnt"}, 32'(flushCnt), 32'h0);
  endtask

  // Monitor: one expectation per modelled edge, compared just after that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        mon = sbQueue.pop_front();
        checkOutput(mon);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bt, jt;
    bit          pcw, ifidw, fl, br, jp;

    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");
    reset = 1'b1;

    // Plan 1: boot cycle then free-running fetch until PC reaches 0x00400010.
    repeat (5) applyStimulus(1, 1, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("runAddr", bus.addr, 32'h0040_0010);

    // Plan 2: two stall edges hold PC and IF/ID, then resume.
    repeat (2) applyStimulus(0, 0, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("stallAddr", bus.addr, 32'h0040_0010);
`ifdef FETCH_PERF_CNT_EN
    checkField("stallCnt2", 32'(stallCnt), 32'd2);
`endif
    applyStimulus(1, 1, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("resumeAddr", bus.addr, 32'h0040_0014);

    // Plan 3: branch plus flush during a stall.
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    applyStimulus(0, 0, 1, 1, 32'h0040_0100, 0, '0);
    @(posedge clk); #2;
    checkField("branchAddr", bus.addr, 32'h0040_0100);
    checkField("branchBubble", 32'(ifidValid), 32'h0);
    applyStimulus(1, 1, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("branchPcPlus4", ifidPcPlus4, 32'h0040_0104);
    checkField("branchInstr", ifidInstr, memWord(32'h0040_0100));

    // Plan 4: jump beats branch.
    applyStimulus(1, 1, 1, 1, 32'h0040_0300, 1, 32'h0040_0200);
    @(posedge clk); #2;
    checkField("jumpWins", bus.addr, 32'h0040_0200);

    // PC+4 wraps to zero.
    applyStimulus(1, 1, 1, 0, '0, 1, 32'hFFFF_FFFC);
    applyStimulus(1, 1, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("wrapAddr", bus.addr, 32'h0);
    checkField("wrapPcPlus4", ifidPcPlus4, 32'h0);

    // Randomized traffic with aligned redirect targets.
    for (int i = 0; i < 400; i++) begin
      pcw   = ($urandom_range(0, 3) != 0);
      ifidw = pcw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 7) == 0);
      jp    = ($urandom_range(0, 9) == 0);
      fl    = (br || jp) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      bt    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      jt    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bt    = bt[31:0];
      jt    = jt[31:0];
      applyStimulus(pcw, ifidw, fl, br, bt, jp, jt);
    end

    // Plan 5: misaligned jump target is truncated and sets the sticky flag.
    applyStimulus(1, 1, 1, 0, '0, 1, 32'h0040_0202);
    @(posedge clk); #2;
    checkField("misalignAddr", bus.addr, 32'h0040_0200);
    checkField("misalignSet", 32'(misalign), 32'h1);
    repeat (3) applyStimulus(1, 1, 0, 0, '0, 0, '0);
    @(posedge clk); #2;
    checkField("misalignSticky", 32'(misalign), 32'h1);

    // Plan 6: asynchronous reset in the middle of a HOLD cycle with a redirect pending.
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0, 0, '0);
    @(posedge clk); #3;
    jump = 1'b1; jumpTarget = 32'h0040_0800;
    reset = 1'b0;
    #1;
    checkResetValues("asyncReset");
    modelReset();
    @(posedge clk); #2;
    checkResetValues("resetHeld");
    reset = 1'b1;
    jump = 1'b0;
    repeat (4) applyStimulus(1, 1, 0, 0, '0, 0, '0);

    repeat (3) @(posedge clk);
    #2;
    testsRun++;
    if (sbQueue.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardDrain: %0d left, expected 0", sbQueue.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
